sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Controller that shares the 1024x8 level-sensitive SRAM between two requesters (A, B) and a clear source.
- Sequences every access as setup/strobe/hold so address and data are stable before and after the write-enable or output-enable pulse.
- Arbitrates round-robin between A and B. Clear has top priority.
- Sits between the producer/consumer blocks and the SRAM; the only block that drives SRAM control pins.

Parameters:
ADDR_W, 10, SRAM address width
DATA_W, 8, SRAM data width

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
a_req  input  1  requester A access request, held until a_done
a_wr  input  1  A: 1=write, 0=read; stable while a_req
a_addr  input  ADDR_W  A address; stable while a_req
a_wdata  input  DATA_W  A write data; stable while a_req
a_done  output  1  one-cycle pulse: A access complete
a_rdata  output  DATA_W  A read data, registered
b_req, b_wr, b_addr, b_wdata, b_done, b_rdata  same as A, for requester B
clr_req  input  1  request full-memory clear, held until clr_done
clr_done  output  1  one-cycle pulse: clear issued
busy  output  1  high in any state except IDLE
mem_addr  output  ADDR_W  SRAM address, registered
mem_wdata  output  DATA_W  SRAM write data, registered
mem_we  output  1  SRAM writeEnable
mem_oe  output  1  SRAM outputEnable
mem_clr  output  1  SRAM reset (clear) strobe
mem_rdata  input  DATA_W  SRAM read data

Behaviour:
- Reset (n_rst=0, asynchronous): state IDLE; all outputs 0, including a_rdata, b_rdata, mem_addr and mem_wdata. mem_we, mem_oe and mem_clr drop immediately, even mid-access. The RR pointer favours A.
- States: IDLE, CLEAR, SETUP, STROBE, HOLD. Single registered FSM. All outputs come from registers.
- IDLE, arbitration in priority order:
  - clr_req=1 → CLEAR.
  - Else only one of a_req/b_req → grant it.
  - Both → grant the one not granted last; the pointer toggles on each A/B grant.
  - On grant: latch owner, wr, addr, wdata into mem_addr/mem_wdata/internal regs → SETUP.
- CLEAR (1 cycle): mem_clr=1, clr_done=1 → IDLE. The RR pointer is unchanged.
- SETUP (1 cycle): mem_addr/mem_wdata hold latched values; mem_we=0, mem_oe=0 → STROBE.
- STROBE (1 cycle):
  - Write: mem_we=1.
  - Read: mem_oe=1, and mem_rdata is registered into owner's rdata at the end of the cycle.
  - → HOLD.
- HOLD (1 cycle): mem_we=0, mem_oe=0, address/data still held. Owner's done=1 → IDLE.
- Latency: request sampled in IDLE at cycle N; done at N+3; next arbitration at N+4. Four cycles per access; clear takes 1 cycle.
- The requester must drop req in the cycle after done. If req is still high in IDLE, it is treated as a new request.
- mem_we and mem_oe are never high together. mem_clr is never high with either of them.
- a_rdata/b_rdata change only at the end of their own read STROBE; otherwise they hold.
- Requests arriving during an access wait; there is no preemption, including by clr_req.
- Address wrap: none. Addresses are passed verbatim. Addr 1023 is valid.
- Req deasserted mid-access: the access completes and done still pulses.
- busy=1 in CLEAR/SETUP/STROBE/HOLD.

Test Plan:
1. Reset, then A write addr 0x3FF data 0xA5 → mem_we high exactly in cycle N+2 with mem_addr=0x3FF, mem_wdata=0xA5; a_done at N+3.
2. A read 0x3FF after test 1 → mem_oe high in N+2; a_rdata=0xA5 from N+3; b_rdata stays 0x00.
3. a_req and b_req asserted same cycle, both held for 3 requests each → grants alternate A,B,A,B,A,B; no overlapping done pulses.
4. clr_req and b_req asserted together in IDLE → CLEAR first (mem_clr one cycle, clr_done), then B serviced; B read of 0x3FF returns 0x00.
5. clr_req raised during A's STROBE → A completes (a_done), then CLEAR next.
6. n_rst pulsed low during STROBE of a write → mem_we/mem_oe/mem_clr=0 asynchronously; no done pulse; next grant goes to A.

Source files
------------

// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
// sram_arbiter
//
// Shares a level-sensitive 1024x8 SRAM between two requesters (A, B) and a
// full-memory clear source. Every A/B access runs as SETUP / STROBE / HOLD, so
// the address and write data are stable for a full cycle on each side of the
// write-enable or output-enable pulse. Clear has top priority; A and B are
// arbitrated round-robin. A running access is never preempted.
//
// Ports
//   clk, n_rst                     clock, asynchronous active-low reset
//   a_req/a_wr/a_addr/a_wdata      requester A command (held until a_done)
//   a_done, a_rdata                A completion pulse, registered read data
//   b_*                            same set for requester B
//   clr_req, clr_done              clear request (held until clr_done) / pulse
//   busy                           controller is not idle
//   mem_addr, mem_wdata            registered SRAM address / write data
//   mem_we, mem_oe, mem_clr        registered SRAM strobes
//   mem_rdata                      SRAM read data
module sram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              a_req,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              clr_req,
    output logic              clr_done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_oe,
    output logic              mem_clr,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    state_t state;
    logic   last_b;   // last A/B grant went to B; reset value makes A favoured
    logic   owner_b;  // current access belongs to B
    logic   wr_q;     // current access is a write
    logic   grant_b;

    // With both requesting, the one not granted last wins.
    assign grant_b = b_req && (!a_req || !last_b);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            owner_b   <= 1'b0;
            wr_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_oe    <= 1'b0;
            mem_clr   <= 1'b0;
            a_done    <= 1'b0;
            b_done    <= 1'b0;
            clr_done  <= 1'b0;
            busy      <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            // Strobes and done flags are single-cycle; each state re-asserts
            // only the ones that belong to the next state.
            mem_we   <= 1'b0;
            mem_oe   <= 1'b0;
            mem_clr  <= 1'b0;
            a_done   <= 1'b0;
            b_done   <= 1'b0;
            clr_done <= 1'b0;

            case (state)
                // IDLE -> arbitration: clear first, then round-robin A/B
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        mem_clr  <= 1'b1;
                        clr_done <= 1'b1;
                        busy     <= 1'b1;
                    end else if (a_req || b_req) begin
                        state     <= SETUP;
                        owner_b   <= grant_b;
                        last_b    <= grant_b;
                        wr_q      <= grant_b ? b_wr : a_wr;
                        mem_addr  <= grant_b ? b_addr : a_addr;
                        mem_wdata <= grant_b ? b_wdata : a_wdata;
                        busy      <= 1'b1;
                    end
                end

                // CLEAR -> back to IDLE; the round-robin pointer is untouched
                CLEAR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                // SETUP -> STROBE: address/data already stable, raise one enable
                SETUP: begin
                    state  <= STROBE;
                    mem_we <= wr_q;
                    mem_oe <= !wr_q;
                end

                // STROBE -> HOLD: capture read data while output-enable is high
                STROBE: begin
                    state <= HOLD;
                    if (!wr_q) begin
                        if (owner_b) b_rdata <= mem_rdata;
                        else         a_rdata <= mem_rdata;
                    end
                    a_done <= !owner_b;
                    b_done <= owner_b;
                end

                // HOLD -> IDLE: enables already low, address/data still held
                HOLD: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
// tb_sram_arbiter
//
// Bench for sram_arbiter: a behavioural SRAM, a reference memory image, and
// one task per scenario, run in sequence from a single initial block.
module tb_sram_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              a_req, a_wr, b_req, b_wr, clr_req;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic              a_done, b_done, clr_done, busy;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_we, mem_oe, mem_clr;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .n_rst(n_rst),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_done(b_done), .b_rdata(b_rdata),
        .clr_req(clr_req), .clr_done(clr_done), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_oe(mem_oe), .mem_clr(mem_clr),
        .mem_rdata(mem_rdata)
    );

    // Behavioural SRAM. When output-enable is low the bus carries the
    // inverted cell, so data captured at the wrong moment shows up as wrong.
    logic [DATA_W-1:0] sram [0:1023];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) sram[i] <= '0;
        end else if (mem_we) begin
            sram[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_oe ? sram[mem_addr] : ~sram[mem_addr];

    // Reference model state
    logic [DATA_W-1:0] ref_mem [0:1023];
    logic [DATA_W-1:0] exp_a_rd, exp_b_rd;
    bit                ref_last_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Protocol watch: strobe exclusivity, done exclusivity, rdata stability.
    int                viol = 0;
    logic [DATA_W-1:0] prev_a_rd = '0, prev_b_rd = '0;
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            if (mem_we && mem_oe) viol++;
            if (mem_clr && (mem_we || mem_oe)) viol++;
            if ((a_done + b_done + clr_done) > 1) viol++;
            if (a_rdata !== prev_a_rd && !a_done) viol++;
            if (b_rdata !== prev_b_rd && !b_done) viol++;
        end
        prev_a_rd = a_rdata;
        prev_b_rd = b_rdata;
    end

    task automatic clear_model();
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; clr_req = 1'b0;
        a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, mem_we, mem_oe, mem_clr, a_done, b_done, clr_done} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 0000000", {busy, mem_we, mem_oe, mem_clr, a_done, b_done, clr_done});
        end
        n_tests++;
        if ({a_rdata, b_rdata, mem_addr, mem_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_data: a_rdata=%h b_rdata=%h mem_addr=%h mem_wdata=%h required all 0", a_rdata, b_rdata, mem_addr, mem_wdata);
        end
        #2 n_rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: busy=%b required 0", busy);
        end
        // A clear from a fresh reset also gives the SRAM defined contents.
        clr_req = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({mem_clr, clr_done, busy} !== 3'b111) begin
            n_fail++; $display("FAIL reset_clear: clr/done/busy=%b required 111", {mem_clr, clr_done, busy});
        end
        clr_req = 1'b0;
        @(negedge clk);
        clear_model();
        exp_a_rd = '0; exp_b_rd = '0; ref_last_b = 1'b1;
    endtask

    // One isolated access from idle, checked cycle by cycle (N = request cycle).
    task automatic test_single(input string tag, input bit use_b, input bit wr,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        if (use_b) begin b_req = 1'b1; b_wr = wr; b_addr = addr; b_wdata = data; end
        else       begin a_req = 1'b1; a_wr = wr; a_addr = addr; a_wdata = data; end
        @(negedge clk);  // N+1
        n_tests++;
        if ({busy, mem_we, mem_oe, mem_addr} !== {1'b1, 1'b0, 1'b0, addr}) begin
            n_fail++; $display("FAIL %s_setup: busy/we/oe=%b%b%b addr=%h required 100 addr=%h", tag, busy, mem_we, mem_oe, mem_addr, addr);
        end
        @(negedge clk);  // N+2
        n_tests++;
        if ({mem_we, mem_oe, mem_addr} !== {wr, ~wr, addr} || (wr && mem_wdata !== data)) begin
            n_fail++; $display("FAIL %s_strobe: we/oe=%b%b addr=%h wdata=%h required %b%b addr=%h wdata=%h", tag, mem_we, mem_oe, mem_addr, mem_wdata, wr, ~wr, addr, data);
        end
        @(negedge clk);  // N+3
        if (wr) ref_mem[addr] = data;
        else if (use_b) exp_b_rd = ref_mem[addr];
        else exp_a_rd = ref_mem[addr];
        ref_last_b = use_b;
        n_tests++;
        if ({a_done, b_done, mem_we, mem_oe} !== {~use_b, use_b, 2'b00}) begin
            n_fail++; $display("FAIL %s_done: a_done/b_done/we/oe=%b required %b", tag, {a_done, b_done, mem_we, mem_oe}, {~use_b, use_b, 2'b00});
        end
        n_tests++;
        if ({a_rdata, b_rdata} !== {exp_a_rd, exp_b_rd}) begin
            n_fail++; $display("FAIL %s_rdata: a_rdata=%h b_rdata=%h required %h %h", tag, a_rdata, b_rdata, exp_a_rd, exp_b_rd);
        end
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);  // N+4
        n_tests++;
        if ({busy, a_done, b_done} !== 3'b000) begin
            n_fail++; $display("FAIL %s_idle: busy/a_done/b_done=%b required 000", tag, {busy, a_done, b_done});
        end
    endtask

    task automatic test_a_write();
        test_single("a_write", 1'b0, 1'b1, 10'h3FF, 8'hA5);
    endtask

    task automatic test_a_read();
        test_single("a_read", 1'b0, 1'b0, 10'h3FF, 8'h00);
    endtask

    task automatic test_round_robin();
        int a_left = 3, b_left = 3, last_done = -1, cyc = 0;
        bit a_w, b_w, exp_b;
        logic [ADDR_W-1:0] a_ad, b_ad;
        logic [DATA_W-1:0] a_d, b_d;
        // Give B the last grant so the pair starts with A.
        test_single("b_read", 1'b1, 1'b0, 10'h3FF, 8'h00);
        a_w = 1'($urandom_range(0, 1)); a_ad = 10'h3FC + 10'($urandom_range(0, 3)); a_d = 8'($urandom);
        b_w = 1'($urandom_range(0, 1)); b_ad = 10'h3FC + 10'($urandom_range(0, 3)); b_d = 8'($urandom);
        a_req = 1'b1; a_wr = a_w; a_addr = a_ad; a_wdata = a_d;
        b_req = 1'b1; b_wr = b_w; b_addr = b_ad; b_wdata = b_d;
        while ((a_left > 0 || b_left > 0) && cyc < 100) begin
            @(negedge clk); cyc++;
            if (a_done || b_done) begin
                exp_b = (a_left > 0 && b_left > 0) ? !ref_last_b : (b_left > 0);
                n_tests++;
                if ({a_done, b_done} !== (exp_b ? 2'b01 : 2'b10)) begin
                    n_fail++; $display("FAIL rr_owner: a_done/b_done=%b%b required %b", a_done, b_done, exp_b ? 2'b01 : 2'b10);
                end
                n_tests++;
                if (cyc - last_done != 4) begin
                    n_fail++; $display("FAIL rr_spacing: %0d cycles between grants, required 4", cyc - last_done);
                end
                last_done = cyc;
                if (a_done) begin
                    if (a_w) ref_mem[a_ad] = a_d; else exp_a_rd = ref_mem[a_ad];
                    ref_last_b = 1'b0; a_left--;
                end
                if (b_done) begin
                    if (b_w) ref_mem[b_ad] = b_d; else exp_b_rd = ref_mem[b_ad];
                    ref_last_b = 1'b1; b_left--;
                end
                n_tests++;
                if ({a_rdata, b_rdata} !== {exp_a_rd, exp_b_rd}) begin
                    n_fail++; $display("FAIL rr_rdata: a_rdata=%h b_rdata=%h required %h %h", a_rdata, b_rdata, exp_a_rd, exp_b_rd);
                end
                if (a_done) begin
                    a_w = 1'($urandom_range(0, 1)); a_ad = 10'h3FC + 10'($urandom_range(0, 3)); a_d = 8'($urandom);
                    a_req = (a_left > 0); a_wr = a_w; a_addr = a_ad; a_wdata = a_d;
                end
                if (b_done) begin
                    b_w = 1'($urandom_range(0, 1)); b_ad = 10'h3FC + 10'($urandom_range(0, 3)); b_d = 8'($urandom);
                    b_req = (b_left > 0); b_wr = b_w; b_addr = b_ad; b_wdata = b_d;
                end
            end
        end
        n_tests++;
        if (a_left != 0 || b_left != 0) begin
            n_fail++; $display("FAIL rr_timeout: %0d A and %0d B requests outstanding, required 0", a_left, b_left);
        end
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clear_priority();
        test_single("pre_clear_write", 1'b0, 1'b1, 10'h3FF, 8'h5A);
        clr_req = 1'b1;
        b_req = 1'b1; b_wr = 1'b0; b_addr = 10'h3FF; b_wdata = 8'h00;
        @(negedge clk);  // N+1: CLEAR
        n_tests++;
        if ({mem_clr, clr_done, busy, mem_we, mem_oe, b_done} !== 6'b111000) begin
            n_fail++; $display("FAIL clr_first: clr/done/busy/we/oe/b_done=%b required 111000", {mem_clr, clr_done, busy, mem_we, mem_oe, b_done});
        end
        clr_req = 1'b0;
        clear_model();
        @(negedge clk);  // N+2: IDLE
        n_tests++;
        if ({mem_clr, clr_done, busy} !== 3'b000) begin
            n_fail++; $display("FAIL clr_one_cycle: clr/done/busy=%b required 000", {mem_clr, clr_done, busy});
        end
        repeat (2) @(negedge clk);  // N+4: B STROBE
        n_tests++;
        if ({mem_oe, mem_we, mem_addr} !== {2'b10, 10'h3FF}) begin
            n_fail++; $display("FAIL clr_b_strobe: oe/we=%b%b addr=%h required 10 addr=3ff", mem_oe, mem_we, mem_addr);
        end
        @(negedge clk);  // N+5
        exp_b_rd = ref_mem[10'h3FF];
        ref_last_b = 1'b1;
        n_tests++;
        if ({b_done, b_rdata} !== {1'b1, exp_b_rd}) begin
            n_fail++; $display("FAIL clr_b_read: b_done=%b b_rdata=%h required 1 %h", b_done, b_rdata, exp_b_rd);
        end
        b_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clear_during_access();
        logic [ADDR_W-1:0] ad;
        logic [DATA_W-1:0] d;
        ad = 10'h3FC + 10'($urandom_range(0, 3)); d = 8'($urandom);
        a_req = 1'b1; a_wr = 1'b1; a_addr = ad; a_wdata = d;
        repeat (2) @(negedge clk);  // N+2: STROBE
        n_tests++;
        if (mem_we !== 1'b1) begin
            n_fail++; $display("FAIL cda_strobe: mem_we=%b required 1", mem_we);
        end
        clr_req = 1'b1;
        @(negedge clk);  // N+3: A completes despite the clear request
        ref_mem[ad] = d; ref_last_b = 1'b0;
        n_tests++;
        if ({a_done, mem_clr, clr_done} !== 3'b100) begin
            n_fail++; $display("FAIL cda_a_done: a_done/clr/clr_done=%b required 100", {a_done, mem_clr, clr_done});
        end
        a_req = 1'b0;
        @(negedge clk);  // N+4: IDLE
        n_tests++;
        if ({mem_clr, clr_done, busy} !== 3'b000) begin
            n_fail++; $display("FAIL cda_idle: clr/done/busy=%b required 000", {mem_clr, clr_done, busy});
        end
        @(negedge clk);  // N+5: CLEAR
        n_tests++;
        if ({mem_clr, clr_done, a_done} !== 3'b110) begin
            n_fail++; $display("FAIL cda_clear: clr/done/a_done=%b required 110", {mem_clr, clr_done, a_done});
        end
        clr_req = 1'b0;
        clear_model();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        int seen = 0, cyc = 0;
        test_single("pre_reset_write", 1'b0, 1'b1, 10'h3FD, 8'h3C);
        a_req = 1'b1; a_wr = 1'b1; a_addr = 10'h100; a_wdata = 8'hC3;
        repeat (2) @(negedge clk);  // N+2: STROBE
        n_tests++;
        if (mem_we !== 1'b1) begin
            n_fail++; $display("FAIL rst_strobe: mem_we=%b required 1", mem_we);
        end
        #2 n_rst = 1'b0;
        #1;
        n_tests++;
        if ({mem_we, mem_oe, mem_clr, busy} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_async: we/oe/clr/busy=%b required 0000", {mem_we, mem_oe, mem_clr, busy});
        end
        a_req = 1'b0;
        exp_a_rd = '0; exp_b_rd = '0; ref_last_b = 1'b1;
        @(negedge clk);
        #2 n_rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (a_done || b_done) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++; $display("FAIL rst_no_done: %0d done pulses after reset, required 0", seen);
        end
        // Before the reset A was granted last; afterwards A must win again.
        a_req = 1'b1; a_wr = 1'b0; a_addr = 10'h3FD;
        b_req = 1'b1; b_wr = 1'b0; b_addr = 10'h3FD;
        while (!(a_done || b_done) && cyc < 10) begin @(negedge clk); cyc++; end
        exp_a_rd = ref_mem[10'h3FD];
        n_tests++;
        if ({a_done, b_done, a_rdata} !== {2'b10, exp_a_rd}) begin
            n_fail++; $display("FAIL rst_next_grant: a_done/b_done=%b%b a_rdata=%h required 10 %h", a_done, b_done, a_rdata, exp_a_rd);
        end
        a_req = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!b_done && cyc < 10) begin @(negedge clk); cyc++; end
        exp_b_rd = ref_mem[10'h3FD]; ref_last_b = 1'b1;
        n_tests++;
        if ({b_done, b_rdata} !== {1'b1, exp_b_rd}) begin
            n_fail++; $display("FAIL rst_b_after: b_done=%b b_rdata=%h required 1 %h", b_done, b_rdata, exp_b_rd);
        end
        b_req = 1'b0;
        @(negedge clk);
    endtask

    // Independent random traffic from A and B with random gaps. The grant at
    // each done is checked against the requests seen three cycles earlier.
    task automatic test_random();
        bit ha [0:599];
        bit hb [0:599];
        int cyc = 0, a_left = 8, b_left = 8, a_gap = 0, b_gap = 1;
        bit a_w, b_w;
        logic [ADDR_W-1:0] a_ad, b_ad;
        logic [DATA_W-1:0] a_d, b_d;
        a_w = 1'b0; b_w = 1'b0; a_ad = '0; b_ad = '0; a_d = '0; b_d = '0;
        ha[0] = 1'b0; hb[0] = 1'b0;
        while ((a_left > 0 || b_left > 0) && cyc < 590) begin
            @(negedge clk); cyc++;
            if (a_done) begin
                n_tests++;
                if (!(cyc >= 3 && ha[cyc-3] && (!hb[cyc-3] || ref_last_b))) begin
                    n_fail++; $display("FAIL rand_grant_a: A granted at cycle %0d, last_b=%b", cyc, ref_last_b);
                end
                if (a_w) ref_mem[a_ad] = a_d; else exp_a_rd = ref_mem[a_ad];
                ref_last_b = 1'b0; a_left--; a_req = 1'b0; a_gap = $urandom_range(0, 2);
            end
            if (b_done) begin
                n_tests++;
                if (!(cyc >= 3 && hb[cyc-3] && (!ha[cyc-3] || !ref_last_b))) begin
                    n_fail++; $display("FAIL rand_grant_b: B granted at cycle %0d, last_b=%b", cyc, ref_last_b);
                end
                if (b_w) ref_mem[b_ad] = b_d; else exp_b_rd = ref_mem[b_ad];
                ref_last_b = 1'b1; b_left--; b_req = 1'b0; b_gap = $urandom_range(0, 2);
            end
            if (a_done || b_done) begin
                n_tests++;
                if ({a_rdata, b_rdata} !== {exp_a_rd, exp_b_rd}) begin
                    n_fail++; $display("FAIL rand_rdata: a_rdata=%h b_rdata=%h required %h %h", a_rdata, b_rdata, exp_a_rd, exp_b_rd);
                end
            end
            if (!a_req && a_left > 0) begin
                if (a_gap == 0) begin
                    a_w = 1'($urandom_range(0, 1)); a_ad = 10'h3FC + 10'($urandom_range(0, 3)); a_d = 8'($urandom);
                    a_req = 1'b1; a_wr = a_w; a_addr = a_ad; a_wdata = a_d;
                end else a_gap--;
            end
            if (!b_req && b_left > 0) begin
                if (b_gap == 0) begin
                    b_w = 1'($urandom_range(0, 1)); b_ad = 10'h3FC + 10'($urandom_range(0, 3)); b_d = 8'($urandom);
                    b_req = 1'b1; b_wr = b_w; b_addr = b_ad; b_wdata = b_d;
                end else b_gap--;
            end
            ha[cyc] = a_req; hb[cyc] = b_req;
        end
        n_tests++;
        if (a_left != 0 || b_left != 0) begin
            n_fail++; $display("FAIL rand_timeout: %0d A and %0d B requests outstanding, required 0", a_left, b_left);
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_invariants();
        n_tests++;
        if (viol != 0) begin
            n_fail++; $display("FAIL protocol: %0d strobe/done/rdata violations, required 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_a_write();
        test_a_read();
        test_round_robin();
        test_clear_priority();
        test_clear_during_access();
        test_reset_mid_write();
        test_random();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
